// File: rtl/mem_arbiter.sv
// Two-port pmem arbiter: shares one line-wide physical memory port between the
// I-cache and D-cache, alternating on contention, with saturating perf counters.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_read,
  input  logic [ADDR_W-1:0] icache_address,
  output logic [LINE_W-1:0] icache_rdata,
  output logic              icache_resp,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [ADDR_W-1:0] dcache_address,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              dcache_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  input  logic              clear_counters,
  output logic [CNT_W-1:0]  icache_count,
  output logic [CNT_W-1:0]  dcache_count,
  output logic [CNT_W-1:0]  conflict_count
);

  typedef enum logic [1:0] {s_idle, s_icache, s_dcache} state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  icnt_q, dcnt_q, ccnt_q;
  logic              i_pend, d_pend, conflict;

  assign i_pend   = icache_read;
  assign d_pend   = dcache_read | dcache_write;
  assign conflict = (state_q == s_idle) & i_pend & d_pend;

  assign icache_rdata = pmem_rdata;
  assign dcache_rdata = pmem_rdata;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    icache_resp  = 1'b0;
    dcache_resp  = 1'b0;
    case (state_q)
      s_idle: begin
        // On a tie, the side that did not win last time gets the grant.
        if (i_pend && (!d_pend || last_grant_q)) begin
          state_d      = s_icache;
          last_grant_d = 1'b0;
        end else if (d_pend) begin
          state_d      = s_dcache;
          last_grant_d = 1'b1;
        end
      end
      s_icache: begin
        pmem_read    = icache_read;
        pmem_address = icache_address;
        icache_resp  = pmem_resp;
        if (pmem_resp) state_d = s_idle;
      end
      s_dcache: begin
        // Write-back wins if the D-cache raises both commands.
        pmem_write   = dcache_write;
        pmem_read    = dcache_read & ~dcache_write;
        pmem_address = dcache_address;
        pmem_wdata   = dcache_wdata;
        dcache_resp  = pmem_resp;
        if (pmem_resp) state_d = s_idle;
      end
      default: state_d = s_idle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= s_idle;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    return (inc && c != '1) ? c + CNT_W'(1) : c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icnt_q <= '0;
      dcnt_q <= '0;
      ccnt_q <= '0;
    end else if (clear_counters) begin
      icnt_q <= '0;
      dcnt_q <= '0;
      ccnt_q <= '0;
    end else begin
      icnt_q <= sat_inc(icnt_q, icache_resp);
      dcnt_q <= sat_inc(dcnt_q, dcache_resp);
      ccnt_q <= sat_inc(ccnt_q, conflict);
    end
  end

  assign icache_count   = icnt_q;
  assign dcache_count   = dcnt_q;
  assign conflict_count = ccnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected completions,
// a monitor pops and checks each resp; a small pmem model answers after lat cycles.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          icache_read, dcache_read, dcache_write;
  logic [AW-1:0] icache_address, dcache_address, pmem_address;
  logic [LW-1:0] icache_rdata, dcache_rdata, dcache_wdata, pmem_wdata, pmem_rdata;
  logic          icache_resp, dcache_resp, pmem_read, pmem_write, pmem_resp;
  logic          clear_counters;
  logic [CW-1:0] icache_count, dcache_count, conflict_count;
  logic          pm_resp, stray_resp;

  assign pmem_resp = pm_resp | stray_resp;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .clear_counters(clear_counters), .icache_count(icache_count),
    .dcache_count(dcache_count), .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          side;  // 0 = I, 1 = D
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;  // rdata for fills, wdata for write-backs
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   lat;
  bit   gap_chk;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic side, input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] d);
    exp_t e;
    e.side = side; e.wr = wr; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  // Responds lat cycles after a command first appears; resets on command drop.
  task automatic pmem_model();
    int wcnt = 0;
    forever begin
      @(posedge clk); #1;
      pm_resp = 1'b0;
      if (pmem_read | pmem_write) begin
        if (wcnt == lat - 1) begin
          pm_resp = 1'b1;
          wcnt = 0;
        end else wcnt++;
      end else wcnt = 0;
    end
  endtask

  task automatic monitor();
    int   cyc = 0;
    int   last_resp = -1;
    bit   cmd_prev = 0;
    bit   gap_prev = 0;
    bit   cmd;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      cmd = pmem_read | pmem_write;
      if (gap_chk && !gap_prev) last_resp = -1;
      if (gap_chk && cmd && !cmd_prev && last_resp >= 0)
        chk("idle_gap", LW'(cyc - last_resp - 1), LW'(1));
      if (icache_resp && dcache_resp) chk("dual_resp", 1, 0);
      if (icache_resp || dcache_resp) begin
        last_resp = cyc;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp actual i=%0b d=%0b required none", icache_resp, dcache_resp);
        end else begin
          e = exp_q.pop_front();
          chk("resp_side", LW'(dcache_resp), LW'(e.side));
          chk("resp_addr", LW'(pmem_address), LW'(e.addr));
          chk("resp_cmd", LW'({pmem_read, pmem_write}), LW'({~e.wr, e.wr}));
          if (e.wr) chk("resp_wdata", pmem_wdata, e.data);
          else      chk("resp_rdata", e.side ? dcache_rdata : icache_rdata, e.data);
        end
      end
      cmd_prev = cmd;
      gap_prev = gap_chk;
    end
  endtask

  // Holds a request for n completions, optionally checking the grant one cycle later.
  task automatic req_side(input bit side, input bit rd, input bit wr, input logic [AW-1:0] a,
                          input logic [LW-1:0] wd, input int n, input bit lat_chk);
    bit got;
    if (!side) begin
      icache_address = a; icache_read = rd;
    end else begin
      dcache_address = a; dcache_wdata = wd; dcache_read = rd; dcache_write = wr;
    end
    if (lat_chk) begin
      @(posedge clk); #1;
      chk("grant_cmd", LW'({pmem_read, pmem_write}), LW'({rd & ~wr, wr}));
      chk("grant_addr", LW'(pmem_address), LW'(a));
      if (wr) chk("grant_wdata", pmem_wdata, wd);
    end
    for (int k = 0; k < n; k++) begin
      got = 0;
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        if (side ? dcache_resp : icache_resp) begin
          got = 1;
          break;
        end
      end
      if (!got) begin
        chk("resp_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    if (!side) icache_read = 1'b0;
    else begin dcache_read = 1'b0; dcache_write = 1'b0; end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [LW-1:0] wd, wd2, wdc;
    bit got;
    rst = 1'b1; icache_read = 0; dcache_read = 0; dcache_write = 0;
    icache_address = '0; dcache_address = '0; dcache_wdata = '0; pmem_rdata = '0;
    clear_counters = 0; pm_resp = 0; stray_resp = 0; gap_chk = 0; lat = 5;
    wd  = {4{32'hDEADBEEF}};
    wd2 = {4{32'hCAFEF00D}};
    wdc = {4{32'h5A5A0F0F}};
    fork
      monitor();
      pmem_model();
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cmd", LW'({pmem_read, pmem_write}), 0);
    chk("rst_resp", LW'({icache_resp, dcache_resp}), 0);
    chk("rst_addr", LW'(pmem_address), 0);
    chk("rst_wdata", pmem_wdata, 0);
    chk("rst_counts", LW'({icache_count, dcache_count, conflict_count}), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Single I fill
    pmem_rdata = {16{8'hA5}};
    push(0, 0, 16'h1230, {16{8'hA5}});
    req_side(0, 1, 0, 16'h1230, '0, 1, 1);
    chk("icount_1", LW'(icache_count), 1);

    // D write-back, then read+write (write wins), then D fill
    push(1, 1, 16'h4000, wd);
    req_side(1, 0, 1, 16'h4000, wd, 1, 1);
    chk("dcount_1", LW'(dcache_count), 1);
    push(1, 1, 16'h4440, wd2);
    req_side(1, 1, 1, 16'h4440, wd2, 1, 1);
    pmem_rdata = {4{32'h01234567}};
    push(1, 0, 16'h2220, {4{32'h01234567}});
    req_side(1, 1, 0, 16'h2220, '0, 1, 1);
    chk("dcount_3", LW'(dcache_count), 3);

    // Contention from reset: I, D, I, D with one idle cycle between transfers
    pulse_reset();
    lat = 3;
    pmem_rdata = {16{8'h3C}};
    push(0, 0, 16'h1000, {16{8'h3C}});
    push(1, 1, 16'h5000, wdc);
    push(0, 0, 16'h1000, {16{8'h3C}});
    push(1, 1, 16'h5000, wdc);
    gap_chk = 1;
    fork
      req_side(0, 1, 0, 16'h1000, '0, 2, 0);
      req_side(1, 0, 1, 16'h5000, wdc, 2, 0);
    join
    gap_chk = 0;
    chk("contend_q_empty", LW'(exp_q.size()), 0);
    chk("conflict_count", LW'(conflict_count), 3);
    chk("contend_icount", LW'(icache_count), 2);
    chk("contend_dcount", LW'(dcache_count), 2);

    // Reset mid write-back
    lat = 8;
    dcache_address = 16'h4000; dcache_wdata = wd; dcache_write = 1'b1;
    @(posedge clk); #1;
    chk("abort_pre_write", LW'(pmem_write), 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("abort_cmd", LW'({pmem_read, pmem_write}), 0);
    chk("abort_resp", LW'(dcache_resp), 0);
    chk("abort_counts", LW'({icache_count, dcache_count, conflict_count}), 0);
    dcache_write = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_idle", LW'({pmem_read, pmem_write}), 0);

    // Saturation at 3, then clear in the same cycle as a resp
    lat = 2;
    pmem_rdata = {16{8'hA5}};
    for (int i = 0; i < 5; i++) push(0, 0, 16'h0040, {16{8'hA5}});
    req_side(0, 1, 0, 16'h0040, '0, 5, 0);
    chk("icount_sat", LW'(icache_count), 3);
    push(0, 0, 16'h0080, {16{8'hA5}});
    icache_address = 16'h0080; icache_read = 1'b1;
    got = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (icache_resp) begin got = 1; break; end
    end
    if (!got) chk("clear_timeout", 0, 1);
    clear_counters = 1'b1;
    @(posedge clk); #1;
    clear_counters = 1'b0; icache_read = 1'b0;
    chk("icount_clear", LW'(icache_count), 0);

    // Stray pmem_resp in idle
    @(posedge clk); #1 stray_resp = 1'b1;
    @(negedge clk);
    chk("stray_resp", LW'({icache_resp, dcache_resp}), 0);
    @(posedge clk); #1 stray_resp = 1'b0;
    chk("stray_cmd", LW'({pmem_read, pmem_write}), 0);
    chk("stray_count", LW'(icache_count), 0);
    push(0, 0, 16'h0ABC, {16{8'hA5}});
    req_side(0, 1, 0, 16'h0ABC, '0, 1, 1);

    repeat (3) @(posedge clk);
    chk("final_q_empty", LW'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
